// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller: FSM states, error codes
// and menu option codes.
package atm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_AUTH     = 4'd1,
        S_LANG     = 4'd2,
        S_MENU     = 4'd3,
        S_BALANCE  = 4'd4,
        S_WITHDRAW = 4'd5,
        S_DEPOSIT  = 4'd6,
        S_TRANSFER = 4'd7
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_RANGE   = 3'd1;
    localparam logic [2:0] ERR_LOCKED  = 3'd2;
    localparam logic [2:0] ERR_PIN     = 3'd3;
    localparam logic [2:0] ERR_MENU    = 3'd4;
    localparam logic [2:0] ERR_FUNDS   = 3'd5;
    localparam logic [2:0] ERR_OVF     = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT = 3'd7;

    localparam logic [2:0] MENU_BALANCE  = 3'd0;
    localparam logic [2:0] MENU_WITHDRAW = 3'd1;
    localparam logic [2:0] MENU_DEPOSIT  = 3'd2;
    localparam logic [2:0] MENU_TRANSFER = 3'd3;
    localparam logic [2:0] MENU_LOGOUT   = 3'd4;

    // Codes above MENU_LOGOUT are rejected by the caller before this is used.
    function automatic state_t menu_target(input logic [2:0] opt);
        state_t tgt;
        tgt = S_IDLE;
        case (opt)
            MENU_BALANCE:  tgt = S_BALANCE;
            MENU_WITHDRAW: tgt = S_WITHDRAW;
            MENU_DEPOSIT:  tgt = S_DEPOSIT;
            MENU_TRANSFER: tgt = S_TRANSFER;
            default:       tgt = S_IDLE;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/atm_acct_lookup.sv
// Maps an external account number onto {hit, index} for the account table.
// Purely combinational; one copy serves the card, another the transfer target.
module atm_acct_lookup #(
    parameter int NUM_ACCTS = 16,
    parameter int ACC_W     = 12,
    parameter int ACC_BASE  = 2000
) (
    input  logic [ACC_W-1:0]             acc,
    output logic                         hit,
    output logic [$clog2(NUM_ACCTS)-1:0] idx
);

    logic [31:0] acc_ext;
    logic [31:0] offset;

    always_comb begin
        acc_ext = 32'(acc);
        offset  = acc_ext - 32'(ACC_BASE);
        hit     = (acc_ext >= 32'(ACC_BASE)) && (offset < 32'(NUM_ACCTS));
        idx     = offset[$clog2(NUM_ACCTS)-1:0];
    end

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN authentication with lockout, language
// select, and single-cycle balance/withdraw/deposit/transfer operations.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int NUM_ACCTS   = 16,
    parameter int ACC_W       = 12,
    parameter int PIN_W       = 14,
    parameter int AMT_W       = 20,
    parameter int ACC_BASE    = 2000,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int INIT_BAL    = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_in,
    input  logic [ACC_W-1:0] account_num,
    input  logic [PIN_W-1:0] pin,
    input  logic             pin_valid,
    input  logic             language,
    input  logic [2:0]       menu_option,
    input  logic             menu_valid,
    input  logic [AMT_W-1:0] amount,
    input  logic [ACC_W-1:0] dest_acc,
    input  logic             exit,
    output logic [AMT_W-1:0] balance,
    output logic             done,
    output logic             error,
    output logic [2:0]       err_code,
    output logic             locked,
    output logic             language_out,
    output logic [3:0]       state
);

    localparam int IDX_W = $clog2(NUM_ACCTS);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    // Carry-out of the widened sum flags an overflow of the AMT_W balance.
    function automatic logic [AMT_W:0] wide_sum(input logic [AMT_W-1:0] a,
                                                input logic [AMT_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    state_t             state_q;
    logic [AMT_W-1:0]   bal_mem [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] lock_bits;
    logic [IDX_W-1:0]   sess_idx;
    logic [TRY_W-1:0]   tries;
    logic [TO_W-1:0]    to_cnt;

    logic               src_hit;
    logic [IDX_W-1:0]   src_idx;
    logic               dst_hit;
    logic [IDX_W-1:0]   dst_idx;

    atm_acct_lookup #(
        .NUM_ACCTS(NUM_ACCTS),
        .ACC_W    (ACC_W),
        .ACC_BASE (ACC_BASE)
    ) u_src_lookup (
        .acc(account_num),
        .hit(src_hit),
        .idx(src_idx)
    );

    atm_acct_lookup #(
        .NUM_ACCTS(NUM_ACCTS),
        .ACC_W    (ACC_W),
        .ACC_BASE (ACC_BASE)
    ) u_dst_lookup (
        .acc(dest_acc),
        .hit(dst_hit),
        .idx(dst_idx)
    );

    logic [AMT_W-1:0] cur_bal;
    logic [AMT_W-1:0] dst_bal;
    logic             wd_ok;
    logic [AMT_W-1:0] wd_res;
    logic [AMT_W:0]   dep_sum;
    logic [AMT_W:0]   xfer_sum;
    logic             pin_ok;
    logic             any_valid;
    logic             waiting;
    logic             timeout_hit;
    logic [TRY_W-1:0] tries_inc;

    assign cur_bal     = bal_mem[sess_idx];
    assign dst_bal     = bal_mem[dst_idx];
    assign wd_ok       = (amount <= cur_bal);
    assign wd_res      = cur_bal - amount;
    assign dep_sum     = wide_sum(cur_bal, amount);
    assign xfer_sum    = wide_sum(dst_bal, amount);
    assign pin_ok      = (pin == PIN_W'(sess_idx));
    assign any_valid   = card_in | pin_valid | menu_valid;
    assign waiting     = (state_q == S_AUTH) || (state_q == S_LANG) || (state_q == S_MENU);
    assign timeout_hit = waiting && !any_valid && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign tries_inc   = tries + TRY_W'(1);

    assign locked = src_hit && lock_bits[src_idx];
    assign state  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            balance      <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
            language_out <= 1'b0;
            lock_bits    <= '0;
            sess_idx     <= '0;
            tries        <= '0;
            to_cnt       <= '0;
            for (int i = 0; i < NUM_ACCTS; i++) begin
                bal_mem[i] <= AMT_W'(INIT_BAL);
            end
        end else begin
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            // Quiet cycles in a waiting state accumulate; anything else restarts the count.
            to_cnt   <= (waiting && !any_valid) ? to_cnt + TO_W'(1) : '0;

            if (exit) begin
                state_q <= S_IDLE;
                to_cnt  <= '0;
            end else if (timeout_hit) begin
                state_q  <= S_IDLE;
                error    <= 1'b1;
                err_code <= ERR_TIMEOUT;
                to_cnt   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (card_in) begin
                            if (!src_hit) begin
                                error    <= 1'b1;
                                err_code <= ERR_RANGE;
                            end else if (lock_bits[src_idx]) begin
                                error    <= 1'b1;
                                err_code <= ERR_LOCKED;
                            end else begin
                                sess_idx <= src_idx;
                                tries    <= '0;
                                state_q  <= S_AUTH;
                            end
                        end
                    end
                    S_AUTH: begin
                        if (pin_valid) begin
                            if (pin_ok) begin
                                tries   <= '0;
                                state_q <= S_LANG;
                            end else begin
                                error    <= 1'b1;
                                err_code <= ERR_PIN;
                                if (tries_inc == TRY_W'(MAX_TRIES)) begin
                                    lock_bits[sess_idx] <= 1'b1;
                                    tries               <= '0;
                                    state_q             <= S_IDLE;
                                end else begin
                                    tries <= tries_inc;
                                end
                            end
                        end
                    end
                    S_LANG: begin
                        language_out <= language;
                        state_q      <= S_MENU;
                        to_cnt       <= '0;
                    end
                    S_MENU: begin
                        if (menu_valid) begin
                            if (menu_option > MENU_LOGOUT) begin
                                error    <= 1'b1;
                                err_code <= ERR_MENU;
                            end else begin
                                state_q <= menu_target(menu_option);
                            end
                        end
                    end
                    S_BALANCE: begin
                        balance <= cur_bal;
                        done    <= 1'b1;
                        state_q <= S_MENU;
                    end
                    S_WITHDRAW: begin
                        if (wd_ok) begin
                            bal_mem[sess_idx] <= wd_res;
                            balance           <= wd_res;
                            done              <= 1'b1;
                        end else begin
                            error    <= 1'b1;
                            err_code <= ERR_FUNDS;
                        end
                        state_q <= S_MENU;
                    end
                    S_DEPOSIT: begin
                        if (dep_sum[AMT_W]) begin
                            error    <= 1'b1;
                            err_code <= ERR_OVF;
                        end else begin
                            bal_mem[sess_idx] <= dep_sum[AMT_W-1:0];
                            balance           <= dep_sum[AMT_W-1:0];
                            done              <= 1'b1;
                        end
                        state_q <= S_MENU;
                    end
                    S_TRANSFER: begin
                        // Checks are ordered so that only one error is reported and no account moves on failure.
                        if (!dst_hit || (dst_idx == sess_idx)) begin
                            error    <= 1'b1;
                            err_code <= ERR_RANGE;
                        end else if (!wd_ok) begin
                            error    <= 1'b1;
                            err_code <= ERR_FUNDS;
                        end else if (xfer_sum[AMT_W]) begin
                            error    <= 1'b1;
                            err_code <= ERR_OVF;
                        end else begin
                            bal_mem[sess_idx] <= wd_res;
                            bal_mem[dst_idx]  <= xfer_sum[AMT_W-1:0];
                            balance           <= wd_res;
                            done              <= 1'b1;
                        end
                        state_q <= S_MENU;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: account-ledger model, per-cycle output compare,
// directed scenarios with literal expectations, then randomized sessions.
module tb_atm_session_ctrl;
    import atm_pkg::*;

    localparam int NUM_ACCTS   = 16;
    localparam int ACC_W       = 12;
    localparam int PIN_W       = 14;
    localparam int AMT_W       = 20;
    localparam int ACC_BASE    = 2000;
    localparam int MAX_TRIES   = 3;
    localparam int TIMEOUT_CYC = 1024;
    localparam int INIT_BAL    = 1000;
    localparam longint MAXV    = (longint'(1) << AMT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             card_in = 1'b0;
    logic [ACC_W-1:0] account_num = '0;
    logic [PIN_W-1:0] pin = '0;
    logic             pin_valid = 1'b0;
    logic             language = 1'b0;
    logic [2:0]       menu_option = '0;
    logic             menu_valid = 1'b0;
    logic [AMT_W-1:0] amount = '0;
    logic [ACC_W-1:0] dest_acc = '0;
    logic             exit = 1'b0;
    logic [AMT_W-1:0] balance;
    logic             done;
    logic             error;
    logic [2:0]       err_code;
    logic             locked;
    logic             language_out;
    logic [3:0]       state;

    always #5 clk = ~clk;

    atm_session_ctrl #(
        .NUM_ACCTS(NUM_ACCTS), .ACC_W(ACC_W), .PIN_W(PIN_W), .AMT_W(AMT_W),
        .ACC_BASE(ACC_BASE), .MAX_TRIES(MAX_TRIES), .TIMEOUT_CYC(TIMEOUT_CYC),
        .INIT_BAL(INIT_BAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .card_in(card_in), .account_num(account_num),
        .pin(pin), .pin_valid(pin_valid), .language(language),
        .menu_option(menu_option), .menu_valid(menu_valid), .amount(amount),
        .dest_acc(dest_acc), .exit(exit), .balance(balance), .done(done),
        .error(error), .err_code(err_code), .locked(locked),
        .language_out(language_out), .state(state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Ledger and session model
    longint bal_m  [NUM_ACCTS];
    bit     lock_m [NUM_ACCTS];
    int     m_state, m_idx, m_tries, m_quiet;
    longint nxt_bal;
    int     nxt_done, nxt_err, nxt_code, nxt_lang;
    longint exp_bal;
    int     exp_state, exp_done, exp_err, exp_code, exp_lang, exp_locked;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    endtask

    function automatic int lookup(input int acc);
        if (acc >= ACC_BASE && acc < ACC_BASE + NUM_ACCTS) return acc - ACC_BASE;
        return -1;
    endfunction

    function automatic int lock_now();
        int s;
        s = lookup(int'(account_num));
        if (s < 0) return 0;
        return int'(lock_m[s]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_ACCTS; i++) begin
            bal_m[i]  = INIT_BAL;
            lock_m[i] = 1'b0;
        end
        m_state = S_IDLE; m_idx = 0; m_tries = 0; m_quiet = 0;
        nxt_bal = 0; nxt_done = 0; nxt_err = 0; nxt_code = 0; nxt_lang = 0;
        exp_bal = 0; exp_state = S_IDLE; exp_done = 0; exp_err = 0; exp_code = 0;
        exp_lang = 0; exp_locked = 0;
    endtask

    task automatic raise(input int code);
        nxt_err  = 1;
        nxt_code = code;
    endtask

    // Advances the ledger/session by one clock using the currently driven inputs.
    task automatic model_step();
        bit     waiting, anyv;
        int     src, dst;
        longint amt;
        nxt_done = 0; nxt_err = 0; nxt_code = 0;
        amt      = longint'(amount);
        waiting  = (m_state == S_AUTH) || (m_state == S_LANG) || (m_state == S_MENU);
        anyv     = card_in || pin_valid || menu_valid;
        if (exit) begin
            m_state = S_IDLE;
            m_quiet = 0;
        end else if (waiting && !anyv && (m_quiet + 1 >= TIMEOUT_CYC)) begin
            raise(ERR_TIMEOUT);
            m_state = S_IDLE;
            m_quiet = 0;
        end else begin
            m_quiet = (waiting && !anyv && m_state != S_LANG) ? m_quiet + 1 : 0;
            case (m_state)
                S_IDLE: if (card_in) begin
                    src = lookup(int'(account_num));
                    if (src < 0) raise(ERR_RANGE);
                    else if (lock_m[src]) raise(ERR_LOCKED);
                    else begin m_idx = src; m_tries = 0; m_state = S_AUTH; end
                end
                S_AUTH: if (pin_valid) begin
                    if (int'(pin) == m_idx) begin
                        m_tries = 0; m_state = S_LANG;
                    end else begin
                        raise(ERR_PIN);
                        m_tries++;
                        if (m_tries >= MAX_TRIES) begin
                            lock_m[m_idx] = 1'b1; m_tries = 0; m_state = S_IDLE;
                        end
                    end
                end
                S_LANG: begin nxt_lang = int'(language); m_state = S_MENU; end
                S_MENU: if (menu_valid) begin
                    case (int'(menu_option))
                        0: m_state = S_BALANCE;
                        1: m_state = S_WITHDRAW;
                        2: m_state = S_DEPOSIT;
                        3: m_state = S_TRANSFER;
                        4: m_state = S_IDLE;
                        default: raise(ERR_MENU);
                    endcase
                end
                S_BALANCE: begin nxt_bal = bal_m[m_idx]; nxt_done = 1; m_state = S_MENU; end
                S_WITHDRAW: begin
                    if (amt <= bal_m[m_idx]) begin
                        bal_m[m_idx] -= amt; nxt_bal = bal_m[m_idx]; nxt_done = 1;
                    end else raise(ERR_FUNDS);
                    m_state = S_MENU;
                end
                S_DEPOSIT: begin
                    if (bal_m[m_idx] + amt > MAXV) raise(ERR_OVF);
                    else begin bal_m[m_idx] += amt; nxt_bal = bal_m[m_idx]; nxt_done = 1; end
                    m_state = S_MENU;
                end
                S_TRANSFER: begin
                    dst = lookup(int'(dest_acc));
                    if (dst < 0 || dst == m_idx) raise(ERR_RANGE);
                    else if (amt > bal_m[m_idx]) raise(ERR_FUNDS);
                    else if (bal_m[dst] + amt > MAXV) raise(ERR_OVF);
                    else begin
                        bal_m[m_idx] -= amt; bal_m[dst] += amt;
                        nxt_bal = bal_m[m_idx]; nxt_done = 1;
                    end
                    m_state = S_MENU;
                end
                default: m_state = S_IDLE;
            endcase
        end
    endtask

    task automatic step();
        exp_locked = lock_now();
        model_step();
        @(posedge clk);
        #1;
        exp_state = m_state; exp_bal = nxt_bal; exp_done = nxt_done;
        exp_err = nxt_err; exp_code = nxt_code; exp_lang = nxt_lang;
        card_in = 1'b0; pin_valid = 1'b0; menu_valid = 1'b0; exit = 1'b0;
        exp_locked = lock_now();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 64'(state), 64'(exp_state));
            chk("balance", 64'(balance), 64'(exp_bal));
            chk("done", 64'(done), 64'(exp_done));
            chk("error", 64'(error), 64'(exp_err));
            chk("err_code", 64'(err_code), 64'(exp_code));
            chk("language_out", 64'(language_out), 64'(exp_lang));
            chk("locked", 64'(locked), 64'(exp_locked));
        end
    end

    task automatic insert(input int acc);
        account_num = ACC_W'(acc); card_in = 1'b1; step();
    endtask

    task automatic enter_pin(input int p);
        pin = PIN_W'(p); pin_valid = 1'b1; step();
    endtask

    task automatic choose(input int opt, input int amt, input int dst);
        menu_option = 3'(opt); amount = AMT_W'(amt); dest_acc = ACC_W'(dst);
        menu_valid = 1'b1; step();
    endtask

    task automatic do_op(input int opt, input int amt, input int dst);
        choose(opt, amt, dst); step();
    endtask

    task automatic login(input int acc);
        insert(acc); enter_pin(acc - ACC_BASE); language = 1'b0; step();
    endtask

    task automatic rand_drive();
        if ($urandom_range(0, 63) == 0) exit = 1'b1;
        if ($urandom_range(0, 31) == 0) card_in = 1'b1;
        case (m_state)
            S_IDLE: if ($urandom_range(0, 1) == 1) begin
                card_in = 1'b1;
                account_num = ACC_W'(ACC_BASE - 2 + int'($urandom_range(0, 19)));
            end
            S_AUTH: if ($urandom_range(0, 1) == 1) begin
                pin_valid = 1'b1;
                pin = ($urandom_range(0, 4) == 0) ? PIN_W'($urandom_range(0, 15)) : PIN_W'(m_idx);
            end
            S_LANG: language = 1'($urandom_range(0, 1));
            S_MENU: if ($urandom_range(0, 2) == 0) begin
                menu_valid  = 1'b1;
                menu_option = 3'($urandom_range(0, 7));
                dest_acc    = ACC_W'(ACC_BASE - 1 + int'($urandom_range(0, 17)));
                case ($urandom_range(0, 3))
                    0: amount = AMT_W'($urandom_range(0, 1200));
                    1: amount = AMT_W'($urandom_range(0, 3000));
                    2: amount = AMT_W'($urandom_range(1040000, 32'(MAXV)));
                    default: amount = AMT_W'(bal_m[m_idx]);
                endcase
            end
            default: ;
        endcase
    endtask

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'(state), 64'(S_IDLE));
        chk("reset_balance", 64'(balance), 64'd0);
        chk("reset_error", 64'(error), 64'd0);
        rst_n = 1'b1;

        // Account 2003 balance inquiry
        insert(2003);
        chk("auth_entry", 64'(state), 64'(S_AUTH));
        enter_pin(3);
        chk("lang_entry", 64'(state), 64'(S_LANG));
        language = 1'b1; step();
        chk("menu_entry", 64'(state), 64'(S_MENU));
        chk("lang_latched", 64'(language_out), 64'd1);
        do_op(0, 0, 0);
        chk("bal_done", 64'(done), 64'd1);
        chk("bal_value", 64'(balance), 64'd1000);
        do_op(1, 1001, 0);
        chk("wd_short_code", 64'(err_code), 64'd5);
        do_op(1, 400, 0);
        chk("wd_ok_done", 64'(done), 64'd1);
        chk("wd_ok_bal", 64'(balance), 64'd600);
        choose(5, 0, 0);
        chk("bad_menu_code", 64'(err_code), 64'd4);
        chk("bad_menu_state", 64'(state), 64'(S_MENU));
        choose(4, 0, 0);
        chk("logout_state", 64'(state), 64'(S_IDLE));

        // Transfers
        login(2001);
        do_op(3, 300, 2002);
        chk("xfer_src_bal", 64'(balance), 64'd700);
        do_op(3, 10, 2001);
        chk("xfer_self_code", 64'(err_code), 64'd1);
        do_op(3, 701, 2002);
        chk("xfer_funds_code", 64'(err_code), 64'd5);
        exit = 1'b1; step();
        chk("exit_state", 64'(state), 64'(S_IDLE));
        login(2002);
        do_op(0, 0, 0);
        chk("xfer_dst_bal", 64'(balance), 64'd1300);
        do_op(3, 5, 2016);
        chk("xfer_range_code", 64'(err_code), 64'd1);
        exit = 1'b1; step();

        // Deposit overflow boundary
        login(2004);
        do_op(2, int'(MAXV) - 999, 0);
        chk("dep_ovf_code", 64'(err_code), 64'd6);
        do_op(2, int'(MAXV) - 1000, 0);
        chk("dep_max_bal", 64'(balance), 64'(MAXV));
        exit = 1'b1; step();

        // PIN lockout
        insert(2005);
        enter_pin(0);
        chk("pin1_code", 64'(err_code), 64'd3);
        enter_pin(1);
        chk("pin2_code", 64'(err_code), 64'd3);
        enter_pin(7);
        chk("pin3_code", 64'(err_code), 64'd3);
        chk("lock_state", 64'(state), 64'(S_IDLE));
        chk("locked_level", 64'(locked), 64'd1);
        insert(2005);
        chk("locked_code", 64'(err_code), 64'd2);

        // Account range edges
        insert(1999);
        chk("range_low_code", 64'(err_code), 64'd1);
        insert(2016);
        chk("range_high_code", 64'(err_code), 64'd1);
        insert(2015);
        chk("range_top_ok", 64'(state), 64'(S_AUTH));
        exit = 1'b1; step();

        // Inactivity timeout, then exit colliding with timeout
        login(2006);
        repeat (TIMEOUT_CYC - 1) step();
        chk("pre_timeout_state", 64'(state), 64'(S_MENU));
        step();
        chk("timeout_code", 64'(err_code), 64'd7);
        chk("timeout_state", 64'(state), 64'(S_IDLE));
        login(2006);
        repeat (TIMEOUT_CYC - 1) step();
        exit = 1'b1; step();
        chk("exit_wins_error", 64'(error), 64'd0);
        chk("exit_wins_state", 64'(state), 64'(S_IDLE));

        // Reset landing in the deposit cycle
        login(2007);
        choose(2, 500, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_state", 64'(state), 64'(S_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        login(2007);
        do_op(0, 0, 0);
        chk("rst_mid_bal", 64'(balance), 64'(INIT_BAL));

        repeat (4000) begin
            rand_drive();
            step();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 SHALL have parameter NUM_ACCTS, default 16: number of accounts held, 2..64.
REQ-002 SHALL have parameter ACC_W, default 12: account-number width.
REQ-003 SHALL have parameter PIN_W, default 14: PIN width.
REQ-004 SHALL have parameter AMT_W, default 20: balance and amount width.
REQ-005 SHALL have parameter ACC_BASE, default 2000: account number of index 0; index i is ACC_BASE+i.
REQ-006 SHALL have parameter MAX_TRIES, default 3: wrong-PIN attempts before the account locks.
REQ-007 SHALL have parameter TIMEOUT_CYC, default 1024: idle cycles before the session is aborted.
REQ-008 SHALL have parameter INIT_BAL, default 1000: reset balance of every account.
REQ-009 SHALL have one clock and an asynchronous, active-low reset: clk in 1 (rising edge); reset in 1 (active-low, asynchronous).
REQ-010 SHALL have these inputs:
- card_in in 1: card-insert pulse.
- account_num in ACC_W.
- pin in PIN_W.
- pin_valid in 1: pulse, PIN presented.
- language in 1: 0 English, 1 French.
- menu_option in 3.
- menu_valid in 1: pulse.
- amount in AMT_W.
- dest_acc in ACC_W.
- exit in 1: abort.
REQ-011 SHALL have these outputs:
- balance out AMT_W.
- done out 1: pulse, operation succeeded.
- error out 1: pulse.
- err_code out 3.
- locked out 1: level.
- language_out out 1.
- state out 4.

Function
REQ-012 SHALL implement states IDLE, AUTH, LANG, MENU, BALANCE, WITHDRAW, DEPOSIT, TRANSFER, with registered state and next-state.
REQ-013 IDLE: card_in with account_num in range and not locked SHALL go to AUTH and latch the index.
- Out of range SHALL give err_code 1.
- Locked account SHALL give err_code 2 and stay in IDLE.
REQ-014 AUTH: pin_valid with a matching PIN SHALL go to LANG and clear the try counter.
- A mismatch SHALL increment the counter and give err_code 3.
- Reaching MAX_TRIES SHALL set that account's lock bit and return to IDLE.
REQ-015 LANG SHALL register language into language_out and go to MENU in one cycle.
REQ-016 MENU: menu_valid SHALL select the next state.
- menu_option 0 selects BALANCE, 1 WITHDRAW, 2 DEPOSIT, 3 TRANSFER, 4 IDLE (logout).
- Codes 5..7 SHALL give err_code 4 and stay in MENU.
REQ-017 BALANCE SHALL drive balance with the stored value, pulse done, and return to MENU.
REQ-018 WITHDRAW: if amount <= balance, SHALL subtract, update balance and pulse done; otherwise err_code 5, no change. Either way it returns to MENU.
REQ-019 DEPOSIT SHALL add with saturation detect: a sum that overflows AMT_W SHALL give err_code 6 with no change; otherwise update and pulse done. It returns to MENU.
REQ-020 TRANSFER SHALL debit the source and credit the destination in the same cycle.
- Destination out of range or equal to the source: err_code 1.
- Insufficient funds: err_code 5.
- Destination overflow: err_code 6.
- On any error, neither balance changes.
REQ-021 Every operation state SHALL last exactly one cycle; done and error SHALL be single-cycle pulses one cycle after entry, and are mutually exclusive.
REQ-022 exit SHALL force IDLE on the next edge from any state, with no balance update in that cycle.
REQ-023 The timeout counter SHALL clear on any valid pulse or state change and count in AUTH/LANG/MENU; reaching TIMEOUT_CYC SHALL force IDLE with err_code 7.
REQ-024 When exit and timeout occur together, exit SHALL win (no error).
REQ-025 locked SHALL reflect the lock bit of account_num every cycle.

Reset
REQ-026 Reset SHALL set:
- state = IDLE;
- balance = 0, done = 0, error = 0, err_code = 0, language_out = 0;
- all balances = INIT_BAL;
- all lock bits, the try counter and the timeout counter = 0.
REQ-027 Reset mid-operation SHALL discard the in-flight update.

Structure
REQ-028 State encodings, err_code values and menu codes SHALL live in package atm_pkg.
REQ-029 The PIN of account i SHALL be the constant i.
REQ-030 Sub-module atm_acct_lookup SHALL map an account number to {hit, index} combinationally and is instantiated twice: source and destination.

Verification
REQ-031 Account 2003, PIN 3, option 0 -> done, balance = 1000.
REQ-032 Account 2005, wrong PIN three times -> err_code 3 ×3; locked = 1; reinsert -> err_code 2.
REQ-033 Withdraw 1001 -> err_code 5; withdraw 400 -> balance 600.
REQ-034 Transfer 300 from 2001 to 2002 -> 2001 = 700, 2002 = 1300; transfer to 2001 -> err_code 1.
REQ-035 Idle in MENU for 1024 cycles -> err_code 7, state IDLE; exit asserted on that same cycle -> no error.
REQ-036 Reset asserted during DEPOSIT -> balance remains INIT_BAL.
